// File: rtl/fod_mmd_core_if.sv
// Control-word / divided-clock bundle between the FOD word generator, the MMD core
// and the retimer/DTC consumers.
interface fod_mmd_core_if #(
  parameter int WDCW = 6,
  parameter int WDTC = 10,
  parameter int WPC  = 16
);
  logic            EN;
  logic [WDCW-1:0] MMD_DCW;
  logic            RT_DCW;
  logic [WDTC-1:0] DTC_DCW;
  logic            DCW_ACK;
  logic            DIV_PULSE;
  logic            CKV_OUT;
  logic            RT_SEL;
  logic [WDTC-1:0] DTC_CODE;
  logic [WDCW-1:0] N_CUR;
  logic            BUSY;
  logic            CLAMP_ERR;
  logic [WPC-1:0]  PERIOD_CNT;

  modport master (
    output EN, MMD_DCW, RT_DCW, DTC_DCW,
    input  DCW_ACK, DIV_PULSE, CKV_OUT, RT_SEL, DTC_CODE, N_CUR, BUSY, CLAMP_ERR, PERIOD_CNT
  );

  modport slave (
    input  EN, MMD_DCW, RT_DCW, DTC_DCW,
    output DCW_ACK, DIV_PULSE, CKV_OUT, RT_SEL, DTC_CODE, N_CUR, BUSY, CLAMP_ERR, PERIOD_CNT
  );
endinterface

// File: rtl/fod_mmd_core.sv
// Multi-modulus divider: applies one sampled control word per whole output period
// and emits the divided clock, terminal-count pulse and per-period RT/DTC word.
module fod_mmd_core #(
  parameter int WDCW = 6,
  parameter int WDTC = 10,
  parameter int NMIN = 4,
  parameter int WPC  = 16
) (
  input  logic          CLK,
  input  logic          RST,
  fod_mmd_core_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [WDCW-1:0] NMIN_W = WDCW'(NMIN);
  localparam logic [WDCW-1:0] ONE_W  = WDCW'(1);

  state_t          state_reg, state_next;
  logic [WDCW-1:0] cnt_reg, cnt_next;
  logic [WDCW-1:0] n_cur_reg, n_cur_next;
  logic            rt_sel_reg, rt_sel_next;
  logic [WDTC-1:0] dtc_code_reg, dtc_code_next;
  logic            clamp_err_reg, clamp_err_next;
  logic [WPC-1:0]  period_cnt_reg, period_cnt_next;
  logic            dcw_ack_reg, dcw_ack_next;
  logic            div_pulse_reg, div_pulse_next;
  logic            ckv_out_reg, ckv_out_next;
  logic            busy_reg, busy_next;
  logic            do_sample;
  logic [WDCW-1:0] n_req;

  assign n_req = (bus.MMD_DCW < NMIN_W) ? NMIN_W : bus.MMD_DCW;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      n_cur_reg      <= NMIN_W;
      rt_sel_reg     <= 1'b0;
      dtc_code_reg   <= '0;
      clamp_err_reg  <= 1'b0;
      period_cnt_reg <= '0;
      dcw_ack_reg    <= 1'b0;
      div_pulse_reg  <= 1'b0;
      ckv_out_reg    <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      n_cur_reg      <= n_cur_next;
      rt_sel_reg     <= rt_sel_next;
      dtc_code_reg   <= dtc_code_next;
      clamp_err_reg  <= clamp_err_next;
      period_cnt_reg <= period_cnt_next;
      dcw_ack_reg    <= dcw_ack_next;
      div_pulse_reg  <= div_pulse_next;
      ckv_out_reg    <= ckv_out_next;
      busy_reg       <= busy_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    n_cur_next      = n_cur_reg;
    rt_sel_next     = rt_sel_reg;
    dtc_code_next   = dtc_code_reg;
    clamp_err_next  = clamp_err_reg;
    period_cnt_next = period_cnt_reg;
    dcw_ack_next    = 1'b0;
    do_sample       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.EN) begin
          do_sample  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt_reg == '0) begin
          period_cnt_next = period_cnt_reg + WPC'(1);
          if (bus.EN) do_sample = 1'b1;
          else        state_next = DRAIN;
        end else begin
          cnt_next = cnt_reg - ONE_W;
        end
      end
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // A new period is loaded with no gap cycle, so the words land on its first cycle.
    if (do_sample) begin
      n_cur_next    = n_req;
      cnt_next      = n_req - ONE_W;
      rt_sel_next   = bus.RT_DCW;
      dtc_code_next = bus.DTC_DCW;
      dcw_ack_next  = 1'b1;
      if (bus.MMD_DCW < NMIN_W) clamp_err_next = 1'b1;
    end

    // Cycle-aligned outputs are derived from next-state values so they stay registered.
    busy_next      = (state_next == RUN);
    div_pulse_next = (state_next == RUN) && (cnt_next == '0);
    ckv_out_next   = (state_next == RUN) && (cnt_next >= (n_cur_next >> 1));
  end

  assign bus.DCW_ACK    = dcw_ack_reg;
  assign bus.DIV_PULSE  = div_pulse_reg;
  assign bus.CKV_OUT    = ckv_out_reg;
  assign bus.RT_SEL     = rt_sel_reg;
  assign bus.DTC_CODE   = dtc_code_reg;
  assign bus.N_CUR      = n_cur_reg;
  assign bus.BUSY       = busy_reg;
  assign bus.CLAMP_ERR  = clamp_err_reg;
  assign bus.PERIOD_CNT = period_cnt_reg;

endmodule

// File: tb/tb_fod_mmd_core.sv
// Self-checking bench for fod_mmd_core against a period-position reference model.
module tb_fod_mmd_core;
  localparam int WDCW = 6;
  localparam int WDTC = 10;
  localparam int NMIN = 4;
  localparam int WPC  = 8;
  localparam logic [29:0] RESET_VEC = {6'b0, 10'd0, 6'd4, 8'd0};

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   verbose = 1'b1;

  fod_mmd_core_if #(.WDCW(WDCW), .WDTC(WDTC), .WPC(WPC)) bus ();

  fod_mmd_core #(.WDCW(WDCW), .WDTC(WDTC), .NMIN(NMIN), .WPC(WPC)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Reference model: position within the current period counted upward from 0.
  int        m_mode;  // 0 idle, 1 in period, 2 one-cycle gap after stopping
  int        m_pos;
  int        m_n;
  bit        m_rt;
  logic [9:0] m_dtc;
  bit        m_clamp;
  int        m_pcnt;

  task automatic model_edge();
    bit start;
    int req;
    start = 1'b0;
    req   = int'(bus.MMD_DCW);
    if (RST) begin
      m_mode = 0; m_pos = 0; m_n = NMIN; m_rt = 0; m_dtc = '0; m_clamp = 0; m_pcnt = 0;
      return;
    end
    case (m_mode)
      0: start = bus.EN;
      1: begin
        if (m_pos == m_n - 1) begin
          m_pcnt = (m_pcnt + 1) % (1 << WPC);
          if (bus.EN) start = 1'b1;
          else        m_mode = 2;
        end else begin
          m_pos++;
        end
      end
      default: m_mode = 0;
    endcase
    if (start) begin
      m_mode = 1;
      m_pos  = 0;
      m_n    = (req < NMIN) ? NMIN : req;
      m_rt   = bus.RT_DCW;
      m_dtc  = bus.DTC_DCW;
      if (req < NMIN) m_clamp = 1'b1;
    end
  endtask

  function automatic logic [29:0] exp_vec();
    logic ack, pulse, ckv, busy;
    ack   = (m_mode == 1) && (m_pos == 0);
    pulse = (m_mode == 1) && (m_pos == m_n - 1);
    ckv   = (m_mode == 1) && (m_pos < (m_n + 1) / 2);
    busy  = (m_mode == 1);
    return {ack, pulse, ckv, busy, m_clamp, m_rt, m_dtc, 6'(m_n), 8'(m_pcnt)};
  endfunction

  function automatic logic [29:0] obs_vec();
    return {bus.DCW_ACK, bus.DIV_PULSE, bus.CKV_OUT, bus.BUSY, bus.CLAMP_ERR,
            bus.RT_SEL, bus.DTC_CODE, bus.N_CUR, bus.PERIOD_CNT};
  endfunction

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
    if (verbose && bus.DCW_ACK)
      $display("txn t=%0t ack N_CUR=%0d RT_SEL=%0d DTC_CODE=%0d PERIOD_CNT=%0d",
               $time, bus.N_CUR, bus.RT_SEL, bus.DTC_CODE, bus.PERIOD_CNT);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.EN = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    bus.EN = 1'b0; bus.MMD_DCW = '0; bus.RT_DCW = 1'b0; bus.DTC_DCW = '0;
    RST = 1'b1;
    tick();
    tick();
    checks++;
    if (obs_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", obs_vec(), RESET_VEC);
    end
    RST = 1'b0;
  endtask

  task automatic test_basic();
    logic [2:0] want;
    do_reset();
    bus.EN = 1'b1; bus.MMD_DCW = 6'd8; bus.RT_DCW = 1'b1; bus.DTC_DCW = 10'd300;
    for (int c = 1; c <= 25; c++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL basic_vec cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (c <= 24) begin
        want = {(c % 8) == 1, (c % 8) == 0, ((c - 1) % 8) < 4};
        checks++;
        if ({bus.DCW_ACK, bus.DIV_PULSE, bus.CKV_OUT} !== want) begin
          errors++;
          $display("FAIL basic_ack_pulse_ckv cyc=%0d got=%b exp=%b", c,
                   {bus.DCW_ACK, bus.DIV_PULSE, bus.CKV_OUT}, want);
        end
      end
      if (c == 1) begin
        checks++;
        if ({bus.RT_SEL, bus.DTC_CODE} !== {1'b1, 10'd300}) begin
          errors++;
          $display("FAIL basic_words got rt=%0d dtc=%0d exp rt=1 dtc=300", bus.RT_SEL, bus.DTC_CODE);
        end
      end
      if (c == 25) begin
        checks++;
        if (bus.PERIOD_CNT !== 8'd3) begin
          errors++;
          $display("FAIL basic_period_cnt got=%0d exp=3", bus.PERIOD_CNT);
        end
      end
    end
  endtask

  task automatic test_alternate();
    int nacks, len, high;
    int exp_len[4];
    exp_len = '{5, 6, 5, 6};
    nacks = 0; len = 0; high = 0;
    do_reset();
    bus.EN = 1'b1; bus.MMD_DCW = 6'd5; bus.DTC_DCW = 10'($urandom); bus.RT_DCW = 1'($urandom);
    for (int c = 0; c < 60 && nacks < 5; c++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL alt_vec cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (bus.DCW_ACK) begin
        if (nacks > 0) begin
          checks++;
          if (len !== exp_len[nacks-1] || high !== 3) begin
            errors++;
            $display("FAIL alt_period idx=%0d got len=%0d high=%0d exp len=%0d high=3",
                     nacks - 1, len, high, exp_len[nacks-1]);
          end
        end
        nacks++; len = 0; high = 0;
        bus.MMD_DCW = (bus.MMD_DCW == 6'd5) ? 6'd6 : 6'd5;
        bus.DTC_DCW = 10'($urandom);
        bus.RT_DCW  = 1'($urandom);
      end
      len++;
      if (bus.CKV_OUT) high++;
    end
    checks++;
    if (nacks < 5) begin
      errors++;
      $display("FAIL alt_timeout got acks=%0d exp=5", nacks);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    bus.EN = 1'b1; bus.MMD_DCW = 6'd2;
    for (int c = 1; c <= 30; c++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL clamp_vec cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (c == 1 || c == 4) begin
        checks++;
        if ({bus.N_CUR, bus.CLAMP_ERR, bus.DCW_ACK, bus.DIV_PULSE} !== {6'd4, 1'b1, c == 1, c == 4}) begin
          errors++;
          $display("FAIL clamp_first cyc=%0d got n=%0d clamp=%0d ack=%0d pulse=%0d exp n=4 clamp=1",
                   c, bus.N_CUR, bus.CLAMP_ERR, bus.DCW_ACK, bus.DIV_PULSE);
        end
      end
      if (bus.DCW_ACK && c >= 5) bus.MMD_DCW = 6'd10;
    end
    checks++;
    if ({bus.CLAMP_ERR, bus.N_CUR} !== {1'b1, 6'd10}) begin
      errors++;
      $display("FAIL clamp_sticky got clamp=%0d n=%0d exp clamp=1 n=10", bus.CLAMP_ERR, bus.N_CUR);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (bus.CLAMP_ERR !== 1'b0) begin
      errors++;
      $display("FAIL clamp_reset got=%0d exp=0", bus.CLAMP_ERR);
    end
  endtask

  task automatic test_en_drop();
    do_reset();
    bus.EN = 1'b1; bus.MMD_DCW = 6'd10; bus.DTC_DCW = 10'd77;
    for (int c = 1; c <= 14; c++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL drop_vec cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (c == 7) bus.EN = 1'b0;
      if (c == 10) begin
        checks++;
        if (bus.DIV_PULSE !== 1'b1) begin
          errors++;
          $display("FAIL drop_pulse got=%0d exp=1", bus.DIV_PULSE);
        end
      end
      if (c == 11) begin
        checks++;
        if ({bus.PERIOD_CNT, bus.BUSY, bus.CKV_OUT, bus.DCW_ACK} !== {8'd1, 3'b000}) begin
          errors++;
          $display("FAIL drop_drain got pcnt=%0d busy=%0d ckv=%0d ack=%0d exp pcnt=1 busy=0 ckv=0 ack=0",
                   bus.PERIOD_CNT, bus.BUSY, bus.CKV_OUT, bus.DCW_ACK);
        end
        bus.EN = 1'b1;
      end
      if (c == 12 || c == 13) begin
        checks++;
        if ({bus.DCW_ACK, bus.BUSY} !== {c == 13, c == 13}) begin
          errors++;
          $display("FAIL drop_restart cyc=%0d got ack=%0d busy=%0d exp ack=%0d busy=%0d",
                   c, bus.DCW_ACK, bus.BUSY, c == 13, c == 13);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.EN = 1'b1; bus.MMD_DCW = 6'd12; bus.RT_DCW = 1'b1; bus.DTC_DCW = 10'd513;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rstmid_vec cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (obs_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL rstmid_abort got=%h exp=%h", obs_vec(), RESET_VEC);
    end
    tick();
    checks++;
    if ({bus.DCW_ACK, bus.BUSY, bus.N_CUR} !== {1'b1, 1'b1, 6'd12}) begin
      errors++;
      $display("FAIL rstmid_restart got ack=%0d busy=%0d n=%0d exp ack=1 busy=1 n=12",
               bus.DCW_ACK, bus.BUSY, bus.N_CUR);
    end
  endtask

  task automatic test_wrap();
    int pulses, len, high;
    int total;
    pulses = 0; len = 0; high = 0;
    total = (1 << WPC) * 63;
    verbose = 1'b0;
    do_reset();
    bus.EN = 1'b1; bus.MMD_DCW = 6'd63;
    for (int c = 1; c <= total + 1; c++) begin
      tick();
      len++;
      if (bus.CKV_OUT) high++;
      if (bus.DIV_PULSE) begin
        pulses++;
        checks++;
        if (len !== 63 || high !== 32 || obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL wrap_period idx=%0d got len=%0d high=%0d vec=%h exp len=63 high=32 vec=%h",
                   pulses, len, high, obs_vec(), exp_vec());
        end
        len = 0; high = 0;
      end
    end
    checks++;
    if (pulses !== (1 << WPC) || bus.PERIOD_CNT !== '0) begin
      errors++;
      $display("FAIL wrap_count got pulses=%0d pcnt=%0d exp pulses=%0d pcnt=0",
               pulses, bus.PERIOD_CNT, 1 << WPC);
    end
    verbose = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      RST        = ($urandom_range(0, 199) == 0);
      bus.EN     = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) bus.MMD_DCW = 6'($urandom);
      bus.RT_DCW  = 1'($urandom);
      bus.DTC_DCW = 10'($urandom);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_vec cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
    RST = 1'b0;
  endtask

  initial begin
    bus.EN = 1'b0; bus.MMD_DCW = '0; bus.RT_DCW = 1'b0; bus.DTC_DCW = '0;
    test_reset();
    test_basic();
    test_alternate();
    test_clamp();
    test_en_drop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
